// File: rtl/snn_fp_pkg.sv
// -----------------------------------------------------------------------------
// snn_fp_pkg
// Shared definitions for the SNN float32 datapath: the float word width,
// a couple of float32 constants, the accumulator FSM state encoding and a
// leading-zero counter used by the adder's normalisation step.
// -----------------------------------------------------------------------------
package snn_fp_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F800000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_e;

    // Leading zeros of a 27-bit word (27 when the word is zero).
    // Scanning upwards means the last hit is the most significant set bit.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// -----------------------------------------------------------------------------
// Addition_Subtraction
// Combinational IEEE-754 single-precision adder/subtractor.
// Round-to-nearest-even; subnormal inputs and results are flushed to zero.
//
// Ports:
//   a, b       float32 operands
//   op         0 = a + b, 1 = a - b
//   Exception  an operand is Inf/NaN, or the result overflowed
//   result     float32 result (quiet NaN when an operand is Inf/NaN,
//              signed Inf on overflow)
// -----------------------------------------------------------------------------
module Addition_Subtraction
    import snn_fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            op,
    output logic            Exception,
    output logic [FP_W-1:0] result
);

    logic        sa, sb, s_big, s_sml, eff_sub, in_exc, rnd_up;
    logic [7:0]  ea, eb, e_big, e_sml, ediff;
    logic [23:0] ma, mb, m_big, m_sml;
    logic [26:0] big_x, sml_x, sml_full, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [24:0] rnd;
    logic [22:0] mant;
    logic [9:0]  e_norm, e_fin;   // two's complement, room for under/overflow

    always_comb begin
        sa = a[31];
        sb = b[31] ^ op;
        ea = a[30:23];
        eb = b[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        in_exc = (ea == 8'hFF) || (eb == 8'hFF);

        // Order operands by magnitude so the subtraction never goes negative.
        if ({ea, ma} >= {eb, mb}) begin
            e_big = ea; m_big = ma; s_big = sa;
            e_sml = eb; m_sml = mb; s_sml = sb;
        end else begin
            e_big = eb; m_big = mb; s_big = sb;
            e_sml = ea; m_sml = ma; s_sml = sa;
        end

        // Align with three extra bits (guard, round, sticky); anything shifted
        // past the sticky position is ORed into it.
        ediff    = e_big - e_sml;
        big_x    = {m_big, 3'b000};
        sml_full = {m_sml, 3'b000};
        if (ediff > 8'd26) begin
            sml_x = {26'd0, |m_sml};
        end else begin
            sml_x    = sml_full >> ediff;
            sml_x[0] = sml_x[0] | ((sml_full & ((27'd1 << ediff) - 27'd1)) != 27'd0);
        end

        eff_sub = s_big ^ s_sml;
        sum = eff_sub ? ({1'b0, big_x} - {1'b0, sml_x})
                      : ({1'b0, big_x} + {1'b0, sml_x});

        // Normalise so the hidden bit sits at bit 26.
        lz = 5'd0;
        if (sum[27]) begin
            norm   = {sum[27:2], sum[1] | sum[0]};
            e_norm = {2'b00, e_big} + 10'd1;
        end else begin
            lz     = lzc27(sum[26:0]);
            norm   = sum[26:0] << lz;
            e_norm = {2'b00, e_big} - {5'd0, lz};
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        // Rounding carry-out leaves 1.000..0, so just bump the exponent.
        if (rnd[24]) begin
            mant  = rnd[23:1];
            e_fin = e_norm + 10'd1;
        end else begin
            mant  = rnd[22:0];
            e_fin = e_norm;
        end

        Exception = in_exc;
        if (in_exc) begin
            result = 32'h7FC00000;
        end else if (sum == 28'd0) begin
            result = FP_ZERO;
        end else if ($signed(e_fin) <= 10'sd0) begin
            result = {s_big, 31'd0};
        end else if ($signed(e_fin) >= 10'sd255) begin
            Exception = 1'b1;
            result    = {s_big, 8'hFF, 23'd0};
        end else begin
            result = {s_big, e_fin[7:0], mant};
        end
    end

endmodule

// File: rtl/potential_accumulator.sv
// -----------------------------------------------------------------------------
// potential_accumulator
// Per-neuron membrane-potential adder. Loads the decayed potential at the
// start of a timestep, adds each accepted float32 weight into it (one per
// cycle), and presents the sum to the decay stage when the timestep closes.
//
// Parameters:
//   MAX_SPIKES  weights accepted per timestep before weight_ready drops
//   CNT_W       spike_count width, 2**CNT_W - 1 >= MAX_SPIKES
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   decayed_potential   float32 start value from the decay stage
//   decayed_valid       pulse: load decayed_potential, open a timestep
//   weight_in/_valid    float32 weight of one incoming spike
//   weight_ready        a weight is accepted this cycle if valid
//   timestep_end        pulse: close the timestep
//   new_potential       accumulated result, held until the next result
//   potential_valid     pulse: new_potential updated
//   spike_count         weights accepted in the current/last timestep
//   exc_flag            sticky: the adder flagged an exception this timestep
//   busy                timestep in progress (ACCUM or DONE)
// -----------------------------------------------------------------------------
module potential_accumulator
    import snn_fp_pkg::*;
#(
    parameter int MAX_SPIKES = 255,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FP_W-1:0]  decayed_potential,
    input  logic             decayed_valid,
    input  logic [FP_W-1:0]  weight_in,
    input  logic             weight_valid,
    output logic             weight_ready,
    input  logic             timestep_end,
    output logic [FP_W-1:0]  new_potential,
    output logic             potential_valid,
    output logic [CNT_W-1:0] spike_count,
    output logic             exc_flag,
    output logic             busy
);

    acc_state_e       state_q, state_d;
    logic [FP_W-1:0]  acc_q, acc_d;
    logic [FP_W-1:0]  newp_q, newp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exc_q, exc_d;
    logic             accept;
    logic             add_exc;
    logic [FP_W-1:0]  add_res;

    Addition_Subtraction u_add (
        .a         (acc_q),
        .b         (weight_in),
        .op        (1'b0),
        .Exception (add_exc),
        .result    (add_res)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        newp_d       = newp_q;
        cnt_d        = cnt_q;
        exc_d        = exc_q;
        weight_ready = 1'b0;
        accept       = 1'b0;

        case (state_q)
            IDLE: begin
                if (decayed_valid) begin
                    acc_d   = decayed_potential;
                    cnt_d   = '0;
                    exc_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                weight_ready = (cnt_q < CNT_W'(MAX_SPIKES));
                accept       = weight_valid & weight_ready;
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A faulting add leaves the potential untouched.
                    if (add_exc) exc_d = 1'b1;
                    else         acc_d = add_res;
                end
                // Capture on the way into DONE (including a same-cycle
                // weight) so new_potential is already valid while
                // potential_valid is high.
                if (timestep_end) begin
                    newp_d  = acc_d;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= FP_ZERO;
            newp_q  <= FP_ZERO;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            newp_q  <= newp_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
        end
    end

    assign new_potential   = newp_q;
    assign potential_valid = (state_q == DONE);
    assign spike_count     = cnt_q;
    assign exc_flag        = exc_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_potential_accumulator.sv
module tb_potential_accumulator;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] decayed_potential;
    logic        decayed_valid;
    logic [31:0] weight_in;
    logic        weight_valid;
    logic        weight_ready;
    logic        timestep_end;
    logic [31:0] new_potential;
    logic        potential_valid;
    logic [7:0]  spike_count;
    logic        exc_flag;
    logic        busy;

    always #5 clk = ~clk;

    potential_accumulator #(.MAX_SPIKES(MAXS), .CNT_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .decayed_potential (decayed_potential),
        .decayed_valid     (decayed_valid),
        .weight_in         (weight_in),
        .weight_valid      (weight_valid),
        .weight_ready      (weight_ready),
        .timestep_end      (timestep_end),
        .new_potential     (new_potential),
        .potential_valid   (potential_valid),
        .spike_count       (spike_count),
        .exc_flag          (exc_flag),
        .busy              (busy)
    );

    typedef struct packed {
        logic [31:0] pot;
        logic [7:0]  cnt;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (potential_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("pv_unexpected", 32'(potential_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("new_potential", new_potential, mon_e.pot);
                chk("spike_count", 32'(spike_count), 32'(mon_e.cnt));
                chk("exc_flag", 32'(exc_flag), 32'(mon_e.exc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        decayed_potential = v;
        decayed_valid     = 1'b1;
        tick();
        decayed_valid     = 1'b0;
        chk("busy_after_load", 32'(busy), 32'd1);
    endtask

    task automatic wt(input logic [31:0] v);
        chk("ready_before_wt", 32'(weight_ready), 32'd1);
        weight_in    = v;
        weight_valid = 1'b1;
        tick();
        weight_valid = 1'b0;
    endtask

    // Close the timestep; any weight the caller left valid is sampled too.
    task automatic close(input logic [31:0] pot, input int cnt, input logic exc);
        sb_q.push_back('{pot, 8'(cnt), exc});
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        weight_valid = 1'b0;
        chk("pv_at_T1", 32'(potential_valid), 32'd1);
        chk("busy_at_T1", 32'(busy), 32'd1);
        chk("ready_in_done", 32'(weight_ready), 32'd0);
        tick();
        chk("pv_at_T2", 32'(potential_valid), 32'd0);
        chk("busy_at_T2", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_newp"},  new_potential, 32'h0);
        chk({tag, "_pv"},    32'(potential_valid), 32'd0);
        chk({tag, "_ready"}, 32'(weight_ready), 32'd0);
        chk({tag, "_cnt"},   32'(spike_count), 32'd0);
        chk({tag, "_exc"},   32'(exc_flag), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        decayed_potential = 32'h0;
        decayed_valid     = 1'b0;
        weight_in         = 32'h0;
        weight_valid      = 1'b0;
        timestep_end      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("por");

        // 27.84 + 1.0
        load(32'h41DEB852);
        wt(32'h3F800000);
        close(32'h41E6B852, 1, 1'b0);

        // 27.84 - 1.0
        load(32'h41DEB852);
        wt(32'hBF800000);
        close(32'h41D6B852, 1, 1'b0);

        // weight in the same cycle as timestep_end is included
        load(32'h40000000);
        weight_in    = 32'h40000000;
        weight_valid = 1'b1;
        close(32'h40800000, 1, 1'b0);

        // empty timestep passes the decayed potential through
        load(32'h3F800000);
        close(32'h3F800000, 0, 1'b0);

        // exact tie at half an ulp rounds to even; just above rounds up
        load(32'h3F800000);
        wt(32'h33800000);
        close(32'h3F800000, 1, 1'b0);
        load(32'h3F800000);
        wt(32'h33800001);
        close(32'h3F800001, 1, 1'b0);

        // 3.0 + 1.0 + 1.0 - 0.5 = 4.5
        load(32'h40400000);
        wt(32'h3F800000);
        wt(32'h3F800000);
        wt(32'hBF000000);
        close(32'h40900000, 3, 1'b0);

        // Inf weight: potential held, exception sticky, count still advances
        load(32'h3F800000);
        wt(32'h3F800000);
        wt(32'h7F800000);
        chk("exc_sticky", 32'(exc_flag), 32'd1);
        wt(32'h3F800000);
        close(32'h40400000, 3, 1'b1);
        load(32'h3F800000);
        chk("exc_cleared_on_load", 32'(exc_flag), 32'd0);
        close(32'h3F800000, 0, 1'b0);

        // saturate at MAX_SPIKES with weight_valid held for 6 cycles
        load(32'h00000000);
        weight_in    = 32'h3F800000;
        weight_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ready_full_%0d", i), 32'(weight_ready), (i < MAXS) ? 32'd1 : 32'd0);
            tick();
        end
        weight_valid = 1'b0;
        chk("cnt_full", 32'(spike_count), 32'(MAXS));
        close(32'h40800000, MAXS, 1'b0);

        // timestep_end and weights in IDLE are ignored
        chk("ready_idle", 32'(weight_ready), 32'd0);
        timestep_end = 1'b1;
        weight_valid = 1'b1;
        tick();
        timestep_end = 1'b0;
        weight_valid = 1'b0;
        chk("pv_idle_end", 32'(potential_valid), 32'd0);
        chk("busy_idle_end", 32'(busy), 32'd0);
        chk("cnt_idle_hold", 32'(spike_count), 32'(MAXS));
        tick();

        // reset in the middle of a timestep
        load(32'h40000000);
        wt(32'h3F800000);
        wt(32'h3F800000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("mid_rst");
        tick();
        chk("pv_after_rst", 32'(potential_valid), 32'd0);

        // normal timestep after the reset
        load(32'h41DEB852);
        wt(32'h3F800000);
        close(32'h41E6B852, 1, 1'b0);

        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/potential_accumulator.md
# potential_accumulator

Per-neuron membrane-potential accumulator sitting directly upstream of the potential decay stage. Each timestep it loads the decayed potential fed back from the decay stage and sums every incoming weighted spike (IEEE-754 single precision) into it. At timestep end it presents the result as `new_potential` to the decay stage. It is the "potential adder" whose output the decay stage consumes.

## Interface
Parameters:
- `MAX_SPIKES`, default 255: maximum weights accepted per timestep; `weight_ready` drops once reached.
- `CNT_W`, default 8: width of `spike_count`; must satisfy 2^CNT_W − 1 ≥ MAX_SPIKES.

Ports:
- `clk` input 1: the single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `decayed_potential` input 32: float32 potential from the decay stage.
- `decayed_valid` input 1: one-cycle pulse; loads `decayed_potential` and starts a timestep.
- `weight_in` input 32: float32 synaptic weight of one incoming spike.
- `weight_valid` input 1: `weight_in` valid.
- `weight_ready` output 1: accumulator can take a weight this cycle.
- `timestep_end` input 1: one-cycle pulse closing the current timestep.
- `new_potential` output 32: accumulated potential, held until the next result.
- `potential_valid` output 1: one-cycle pulse; `new_potential` updated.
- `spike_count` output CNT_W: weights accepted in the current or last timestep.
- `exc_flag` output 1: sticky; adder raised Exception this timestep.
- `busy` output 1: high in ACCUM or DONE.

## Operation
- FSM states: IDLE → ACCUM → DONE → IDLE.
- **IDLE.** `weight_ready` = 0. On `decayed_valid`:
  - `acc` ← `decayed_potential`;
  - `spike_count` ← 0;
  - `exc_flag` ← 0;
  - go to ACCUM.
  - `timestep_end` and `weight_valid` in IDLE are ignored; weights stall.
- **ACCUM.** `weight_ready` = (`spike_count` < MAX_SPIKES).
  - A weight is accepted when `weight_valid` & `weight_ready`. On accept: `acc` ← `acc` + `weight_in` through combinational Addition_Subtraction (op = 0, add), and `spike_count` increments.
  - If the adder Exception is high on an accepted weight: `acc` holds its value, `exc_flag` ← 1, `spike_count` still increments.
  - `decayed_valid` in ACCUM is ignored.
  - `timestep_end` moves the FSM to DONE. A weight accepted in the same cycle is included in the result.
- **DONE.** Lasts one cycle; `weight_ready` = 0.
  - `new_potential` ← `acc`, `potential_valid` = 1.
  - Next state is IDLE.
- Float handling is delegated entirely to Addition_Subtraction. Sign, exponent and mantissa are not interpreted here.

## Timing
- Reset values: `new_potential` = 0, `potential_valid` = 0, `weight_ready` = 0, `spike_count` = 0, `exc_flag` = 0, `busy` = 0, `acc` = 0, FSM = IDLE.
- `rst` has priority over every other input in the same cycle. Reset mid-ACCUM discards `acc` and emits no `potential_valid`.
- Throughput is one weight per cycle in ACCUM.
- Load to first accept: `decayed_valid` at cycle N allows the first accept at N+1.
- Latency: `timestep_end` at cycle T gives `potential_valid` high in cycle T+1 with `new_potential` valid. `busy` falls at T+2.
- Full: once `spike_count` = MAX_SPIKES, `weight_ready` is 0 from the next cycle. `timestep_end` still completes normally.
- An empty timestep (no weights) gives `new_potential` = `decayed_potential`.
- The earliest next `decayed_valid` is accepted at T+2, in IDLE.

## Structure
- Shared package `snn_fp_pkg`:
  - state enum (IDLE/ACCUM/DONE);
  - float32 constants `FP_ZERO` = 32'h00000000 and `FP_ONE` = 32'h3F800000;
  - the `FP_W` = 32 width constant.
- One sub-module: the existing `Addition_Subtraction` (a, b, op, Exception, result), instantiated once with a = `acc` and b = `weight_in`.
- No other submodules: FSM, counter and registers are local.

## Test plan
- Load 32'h41DEB852 (27.84), one weight 32'h3F800000, then `timestep_end` → `potential_valid` one cycle later, `new_potential` = 32'h41E6B852, `spike_count` = 1.
- Load 32'h41DEB852, weight 32'hBF800000, end → 32'h41D6B852.
- Load 32'h40000000, weight 32'h40000000 in the same cycle as `timestep_end` → 32'h40800000, `spike_count` = 1.
- Load 32'h3F800000, no weights, end → 32'h3F800000, `spike_count` = 0.
- MAX_SPIKES = 4: load 0, hold `weight_valid` for 6 cycles with 32'h3F800000 → `weight_ready` low after 4 accepts, result 32'h40800000; `timestep_end` in IDLE produces no pulse.
- Assert `rst` mid-ACCUM after 2 weights → all outputs at reset values next cycle, no `potential_valid`; a subsequent normal timestep is correct.
